multichan_rr_accum: RTL and testbench
=====================================

Name: multichan_rr_accum

Overview:
Multi-channel accumulator engine and parametrised successor to the fixed 32-bit/5-channel top-level datapath blocks.
- Each accepted input word carries a channel index and is combined with that channel's state register using a runtime-selected mode.
- Results queue in an output FIFO with valid/ready handshake.
- A flush command dumps all channel states in channel order, then clears them.

Parameters:
WIDTH, 32, data width in bits (≥8)
CHANNEL, 5, number of channel state registers (≥2)
DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept input
in_data  input  WIDTH  input word
in_ch  input  CH_W  target channel; CH_W = max(1, clog2(CHANNEL))
mode  input  2  00 pass, 01 add, 10 xor, 11 rotl1-xor
flush  input  1  single-cycle flush request
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  WIDTH  result word
out_ch  output  CH_W  channel of result
out_last  output  1  last word of a flush dump
err  output  1  sticky: an input had in_ch ≥ CHANNEL

Behaviour:
- Reset (rst=1 at an edge, any state):
  - all channel states = 0; FIFO emptied; FSM = RUN; err = 0.
  - Outputs during and after reset: out_valid=0, out_data=0, out_ch=0, out_last=0.
  - in_ready=0 while rst=1.
  - Reset mid-flush aborts the dump with no further outputs.
- Transfers: an input is accepted when in_valid & in_ready at an edge; an output pops when out_valid & out_ready.
- in_ready = (state==RUN) & (fifo_count < DEPTH). There is no full-FIFO pass-through, even when a pop happens in the same cycle.
- Accepted input with in_ch < CHANNEL: result r computed combinationally from state s:
  - pass: r = in_data
  - add: r = s + in_data mod 2^WIDTH
  - xor: r = s ^ in_data
  - rotl1-xor: r = {s[WIDTH-2:0], s[WIDTH-1]} ^ in_data
  - At the same edge s <= r and {r, in_ch, last=0} is pushed.
  - out_valid rises the next cycle (latency 1).
- Accepted input with in_ch ≥ CHANNEL: consumed, no push, no state change, err <= 1. err clears only on rst.
- Simultaneous push and pop: both occur; count unchanged.
- FSM states:
  - RUN: flush=1 → FLUSH with index k=0. If in_valid & in_ready are also high that cycle, the input is applied first and its effect appears in the dump.
  - FLUSH: in_ready=0; flush input ignored. Each cycle with FIFO not full (pop that same cycle does not count as space), push {state[k], k, last=(k==CHANNEL-1)}, clear state[k], k++. After pushing k=CHANNEL-1 → RUN.
- FIFO order is strict; out_data/out_ch/out_last are stable while out_valid & !out_ready.

Optional Feature:
MULTICHAN_RR_ACCUM_SAT_EN:
- Defined: add mode saturates; any carry out of WIDTH bits forces r = all-ones. Other modes are unchanged.
- Undefined: add wraps modulo 2^WIDTH.

Decomposition:
- Package multichan_rr_accum_pkg:
  - mode enum (MODE_PASS, MODE_ADD, MODE_XOR, MODE_ROTX)
  - FSM state enum (ST_RUN, ST_FLUSH)
  - a combine function (state, data, mode) → result, honouring the SAT macro
- Sub-module mcra_fifo: synchronous FIFO, WIDTH+CH_W+1 wide, DEPTH deep. Ports push/pop/full/empty/count; synchronous active-high reset.

Test Plan:
Defaults: WIDTH=32, CHANNEL=5, DEPTH=4, out_ready=1 unless stated.
1. rst=1 for 5 cycles → in_ready=0 and out_valid=0 throughout; in_ready=1 the cycle after release; err=0.
2. mode=01, ch2: 0xabcdefab then 0x12345678 → outputs 0xabcdefab then 0xbe024623, out_ch=2, each one cycle after acceptance.
3. mode=10, ch0: 0xaaaaaaaa twice → 0xaaaaaaaa then 0x00000000. mode=11, ch3: 0x80000001 then 0 → 0x80000001 then 0x00000003.
4. out_ready=0, 5 inputs offered → 4 accepted, in_ready=0 on the 5th. Raise out_ready → 4 outputs in order, then the 5th is accepted.
5. After test 2, pulse flush:
   - outputs (ch,data) = (0,0),(1,0),(2,0xbe024623),(3,0),(4,0), out_last only on ch4.
   - Then mode=01 ch2 0xaaaaaaaa → 0xaaaaaaaa.
   - Separately: in_ch=7 → no output, err=1 held until rst.
6. mode=01, ch1: 0xffffffff then 0x00000002 → second output 0x00000001, or 0xffffffff with SAT_EN. Separately: rst after 2 flush words → no further outputs, all states read 0 on a later flush.

Source files
------------

// File: rtl/multichan_rr_accum_pkg.sv
// Shared types and the per-channel combine function for multichan_rr_accum.
// Build option MULTICHAN_RR_ACCUM_SAT_EN: add mode saturates to all-ones on carry out.
package multichan_rr_accum_pkg;

  // Widest datapath the combine function supports; operands are zero-extended to it.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_ROTX = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // w is the live width; inputs must be zero above bit w-1, result is masked to w bits.
  function automatic logic [MAX_W-1:0] combine(input logic [MAX_W-1:0] s,
                                               input logic [MAX_W-1:0] d,
                                               input mode_e m,
                                               input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
`ifdef MULTICHAN_RR_ACCUM_SAT_EN
    logic [MAX_W:0] sum;
`endif
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    r = '0;
    case (m)
      MODE_PASS: r = d;
      MODE_ADD: begin
`ifdef MULTICHAN_RR_ACCUM_SAT_EN
        sum = {1'b0, s} + {1'b0, d};
        r = ((sum >> w) != '0) ? '1 : sum[MAX_W-1:0];
`else
        r = s + d;
`endif
      end
      MODE_XOR:  r = s ^ d;
      MODE_ROTX: r = ((s << 1) | (s >> (w - 1))) ^ d;
      default:   r = d;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/multichan_rr_accum_fifo.sv
// Synchronous FIFO for result words; push when full and pop when empty are ignored.
module mcra_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/multichan_rr_accum.sv
// Multi-channel accumulator with result FIFO and ordered flush dump of all channel states.
// Build option MULTICHAN_RR_ACCUM_SAT_EN selects saturating add (see package).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | accept inputs, combine into channel state, push results
//   ST_FLUSH | push state[k] one channel per cycle with space, clear it
module multichan_rr_accum
  import multichan_rr_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHANNEL = 5,
  parameter int DEPTH = 4,
  localparam int CH_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             err
);

  localparam int FW = WIDTH + CH_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNEL);

  state_e           state_q;
  state_e           state_d;
  logic [CH_W-1:0]  k_q;
  logic             k_last;
  logic [WIDTH-1:0] ch_state [CHANNEL];
  logic             err_q;

  logic [WIDTH-1:0] s_sel;
  logic [WIDTH-1:0] flush_word;
  logic [WIDTH-1:0] r;
  logic             ch_ok;
  logic             acc_fire;
  logic             in_ready_int;
  logic             run_push;
  logic             flush_push;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    push_data;
  logic [FW-1:0]    head;
  logic             show_head;

  assign ch_ok  = ({1'b0, in_ch} < CH_LIM);
  assign k_last = (k_q == CH_W'(CHANNEL - 1));

  always_comb begin
    s_sel = '0;
    flush_word = '0;
    for (int i = 0; i < CHANNEL; i++) begin
      if (in_ch == CH_W'(i)) s_sel = ch_state[i];
      if (k_q == CH_W'(i))   flush_word = ch_state[i];
    end
  end

  assign r = WIDTH'(combine(MAX_W'(s_sel), MAX_W'(in_data), mode_e'(mode), WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if (!fifo_full && k_last) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Input readiness uses the registered count only: a same-cycle pop never frees a slot.
  always_comb begin
    in_ready_int = 1'b0;
    run_push     = 1'b0;
    flush_push   = 1'b0;
    push_data    = {r, in_ch, 1'b0};
    case (state_q)
      ST_RUN: begin
        in_ready_int = !rst && (fifo_count < CW'(DEPTH));
        run_push     = in_valid && in_ready_int && ch_ok;
      end
      ST_FLUSH: begin
        flush_push = !fifo_full;
        push_data  = {flush_word, k_q, k_last};
      end
      default: ;
    endcase
  end

  assign acc_fire = in_valid & in_ready_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < CHANNEL; i++) ch_state[i] <= '0;
    end else begin
      if (acc_fire && !ch_ok) err_q <= 1'b1;
      if (state_q == ST_RUN)  k_q <= '0;
      else if (flush_push)    k_q <= k_last ? '0 : k_q + 1'b1;
      for (int i = 0; i < CHANNEL; i++) begin
        if (run_push && in_ch == CH_W'(i))  ch_state[i] <= r;
        if (flush_push && k_q == CH_W'(i)) ch_state[i] <= '0;
      end
    end
  end

  assign show_head = !fifo_empty && !rst;
  assign fifo_push = run_push | flush_push;
  assign fifo_pop  = show_head & out_ready;

  mcra_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {out_data, out_ch, out_last} = show_head ? head : '0;
  assign out_valid = show_head;
  assign in_ready  = in_ready_int;
  assign err       = err_q;

endmodule

// File: tb/tb_multichan_rr_accum.sv
// Scoreboard bench for multichan_rr_accum: stimulus pushes expected words, a monitor pops and compares.
module tb_multichan_rr_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_ch;
  logic [1:0]  mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_ch;
  logic        out_last;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  multichan_rr_accum #(
    .WIDTH   (32),
    .CHANNEL (5),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .mode      (mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .err       (err)
  );

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h expected=none", {out_data, out_ch, out_last});
        end else begin
          check("out_word", {out_data, out_ch, out_last}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [2:0] c, input logic [31:0] d,
                      input logic has_exp, input logic [31:0] e);
    int n;
    n = 0;
    mode = m; in_ch = c; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept ch=%0d", c);
      in_valid = 1'b0;
      return;
    end
    if (has_exp) exp_q.push_back({e, c, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_left expected=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic expect_zero_dump();
    for (int c = 0; c < 5; c++) exp_q.push_back({32'h0, 3'(c), (c == 4)});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; mode = '0;
    flush = 1'b0; out_ready = 1'b1;

    // reset hold
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_in_ready", 36'(in_ready), 36'(0));
      check("rst_out_valid", 36'(out_valid), 36'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 36'(in_ready), 36'(1));
    check("post_rst_err", 36'(err), 36'(0));
    check("post_rst_out", {out_data, out_ch, out_last}, 36'(0));
    @(posedge clk);
    #1;

    // add on ch2, one-cycle latency
    send(2'b01, 3'd2, 32'habcdefab, 1'b1, 32'habcdefab);
    @(negedge clk);
    check("latency_out_valid", 36'(out_valid), 36'(1));
    @(posedge clk);
    #1;
    send(2'b01, 3'd2, 32'h12345678, 1'b1, 32'hbe024623);
    drain("add");

    // flush dump in channel order, then state cleared
    exp_q.push_back({32'h0, 3'd0, 1'b0});
    exp_q.push_back({32'h0, 3'd1, 1'b0});
    exp_q.push_back({32'hbe024623, 3'd2, 1'b0});
    exp_q.push_back({32'h0, 3'd3, 1'b0});
    exp_q.push_back({32'h0, 3'd4, 1'b1});
    pulse_flush();
    @(negedge clk);
    check("flush_in_ready", 36'(in_ready), 36'(0));
    drain("flush");
    check("after_flush_in_ready", 36'(in_ready), 36'(1));
    send(2'b01, 3'd2, 32'haaaaaaaa, 1'b1, 32'haaaaaaaa);
    drain("post_flush_add");

    // xor and rotl1-xor
    send(2'b10, 3'd0, 32'haaaaaaaa, 1'b1, 32'haaaaaaaa);
    send(2'b10, 3'd0, 32'haaaaaaaa, 1'b1, 32'h00000000);
    send(2'b11, 3'd3, 32'h80000001, 1'b1, 32'h80000001);
    send(2'b11, 3'd3, 32'h00000000, 1'b1, 32'h00000003);
    drain("xor_rotx");

    // backpressure: 4 fill the FIFO, 5th waits until a pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b00, 3'd0, 32'h1000 + 32'(i), 1'b1, 32'h1000 + 32'(i));
    mode = 2'b00; in_ch = 3'd0; in_data = 32'h2000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 36'(in_ready), 36'(0));
      check("stall_head", {out_data, out_ch, out_last}, {32'h1000, 3'd0, 1'b0});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(2'b00, 3'd0, 32'h2000, 1'b1, 32'h2000);
    drain("backpressure");

    // out-of-range channel: no output, sticky err
    send(2'b01, 3'd7, 32'h55, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("err_set", 36'(err), 36'(1));
    check("err_no_out", 36'(out_valid), 36'(0));

    // add overflow on ch1
    send(2'b01, 3'd1, 32'hffffffff, 1'b1, 32'hffffffff);
`ifdef MULTICHAN_RR_ACCUM_SAT_EN
    send(2'b01, 3'd1, 32'h00000002, 1'b1, 32'hffffffff);
`else
    send(2'b01, 3'd1, 32'h00000002, 1'b1, 32'h00000001);
`endif
    drain("overflow");
    check("err_held", 36'(err), 36'(1));

    // reset after two flush words are queued: nothing more comes out
    out_ready = 1'b0;
    pulse_flush();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midflush_rst_in_ready", 36'(in_ready), 36'(0));
    check("midflush_rst_out_valid", 36'(out_valid), 36'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("err_cleared", 36'(err), 36'(0));
    check("midflush_no_out", 36'(out_valid), 36'(0));
    repeat (10) @(posedge clk);
    #1;

    // every channel state must read back zero
    expect_zero_dump();
    pulse_flush();
    drain("zero_dump");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
